// File: rtl/tsu_queue_mux_if.sv
// rtl/tsu_queue_mux_if.sv - channel queue and output FIFO port bundle for tsu_queue_mux

interface tsu_queue_mux_if #(
  parameter int NCH   = 2,
  parameter int DW    = 64,
  parameter int SW    = 8,
  parameter int DEPTH = 16
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [NCH-1:0]    ch_en;
  logic [NCH*SW-1:0] ch_rd_stat;
  logic [NCH*DW-1:0] ch_rd_data;
  logic [NCH-1:0]    ch_rd_en;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ch;
  logic [LW-1:0]     out_level;
  logic              busy;

  modport master (
    input  ch_en, ch_rd_stat, ch_rd_data, out_ready,
    output ch_rd_en, out_valid, out_data, out_ch, out_level, busy
  );

  modport slave (
    output ch_en, ch_rd_stat, ch_rd_data, out_ready,
    input  ch_rd_en, out_valid, out_data, out_ch, out_level, busy
  );
endinterface

// File: rtl/tsu_queue_mux.sv
// rtl/tsu_queue_mux.sv - round-robin merger of tsu timestamp queues into a tagged FWFT FIFO

module tsu_queue_mux #(
  parameter int NCH      = 2,
  parameter int DW       = 64,
  parameter int SW       = 8,
  parameter int DEPTH    = 16,
  parameter int RD_LAT   = 1,
  parameter int STAT_LAT = 2
) (
  input  logic             q_rd_clk,
  input  logic             rst_n,
  tsu_queue_mux_if.master  bus
);
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LW        = $clog2(DEPTH) + 1;
  localparam int AW        = $clog2(DEPTH);
  localparam int CNT_W     = 16;
  // last counter value in WAIT / HOLD; only meaningful when that state is reachable
  localparam int WAIT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;
  localparam int HOLD_LAST = (STAT_LAT > 0) ? STAT_LAT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_CAP,
    S_HOLD
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CW-1:0]      ptr;
  logic [CW-1:0]      gnt_q;
  logic [NCH-1:0]     rd_en_q;
  logic [NCH-1:0]     req;
  logic               gnt_found;
  logic [CW-1:0]      gnt_idx;
  logic               fifo_room;
  logic               issue;
  logic               push;
  logic               pop;
  logic               busy_c;
  logic [DW-1:0]      cap_data;

  logic [DW-1:0]      mem_data [DEPTH];
  logic [CW-1:0]      mem_ch   [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LW-1:0]      level;

  // a channel requests when enabled and its queue reports a nonzero fill count
  always_comb begin
    req = '0;
    for (int i = 0; i < NCH; i++) begin
      req[i] = bus.ch_en[i] && (bus.ch_rd_stat[i*SW +: SW] != '0);
    end
  end

  // round-robin pick: first requester at or above ptr, else first requester below it
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!gnt_found && req[i] && (CW'(i) >= ptr)) begin
        gnt_found = 1'b1;
        gnt_idx   = CW'(i);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!gnt_found && req[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = CW'(i);
      end
    end
  end

  assign fifo_room = (level < LW'(DEPTH));

  // FSM state register
  always_ff @(posedge q_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: one pop in flight, FIFO room checked only at issue
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (gnt_found && fifo_room) state_nxt = S_RD;
      S_RD:   state_nxt = (RD_LAT > 1) ? S_WAIT : S_CAP;
      S_WAIT: if (cnt == CNT_W'(WAIT_LAST)) state_nxt = S_CAP;
      S_CAP:  state_nxt = (STAT_LAT > 0) ? S_HOLD : S_IDLE;
      S_HOLD: if (cnt == CNT_W'(HOLD_LAST)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: issue a grant on leaving IDLE, push in CAP
  always_comb begin
    issue  = 1'b0;
    push   = 1'b0;
    busy_c = 1'b1;
    case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        issue  = (state_nxt == S_RD);
      end
      S_CAP:   push = 1'b1;
      default: ;
    endcase
  end

  // dwell counter for WAIT and HOLD, restarted on every state change
  always_ff @(posedge q_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == S_WAIT || state == S_HOLD) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // latch the grant, drive the one-cycle pop strobe, advance ptr past the captured channel
  always_ff @(posedge q_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      rd_en_q <= '0;
      ptr     <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        rd_en_q[i] <= issue && (gnt_idx == CW'(i));
      end
      if (issue) begin
        gnt_q <= gnt_idx;
      end
      if (push) begin
        ptr <= (gnt_q == CW'(NCH - 1)) ? '0 : gnt_q + CW'(1);
      end
    end
  end

  // select the granted channel's record for capture
  always_comb begin
    cap_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_q == CW'(i)) cap_data = bus.ch_rd_data[i*DW +: DW];
    end
  end

  assign pop = (level != '0) && bus.out_ready;

  // FIFO storage, written at the end of CAP
  always_ff @(posedge q_rd_clk) begin
    if (push) begin
      mem_data[wr_ptr] <= cap_data;
      mem_ch[wr_ptr]   <= gnt_q;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged
  always_ff @(posedge q_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // head is forced to zero while empty so the port reads clean after reset
  assign bus.out_valid = (level != '0);
  assign bus.out_data  = bus.out_valid ? mem_data[rd_ptr] : '0;
  assign bus.out_ch    = bus.out_valid ? mem_ch[rd_ptr] : '0;
  assign bus.out_level = level;
  assign bus.ch_rd_en  = rd_en_q;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_tsu_queue_mux.sv
// tb/tb_tsu_queue_mux.sv - directed self-checking bench for tsu_queue_mux

module tb_tsu_queue_mux;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: 4 channels, 4-deep FIFO, RD_LAT=1, STAT_LAT=2
  tsu_queue_mux_if #(.NCH(4), .DW(64), .SW(8), .DEPTH(4)) ifa ();
  tsu_queue_mux #(.NCH(4), .DW(64), .SW(8), .DEPTH(4), .RD_LAT(1), .STAT_LAT(2)) dut_a (
    .q_rd_clk (clk),
    .rst_n    (rst_a),
    .bus      (ifa)
  );

  // instance B: 2 channels, 16-deep FIFO, RD_LAT=3, STAT_LAT=0
  tsu_queue_mux_if #(.NCH(2), .DW(64), .SW(8), .DEPTH(16)) ifb ();
  tsu_queue_mux #(.NCH(2), .DW(64), .SW(8), .DEPTH(16), .RD_LAT(3), .STAT_LAT(0)) dut_b (
    .q_rd_clk (clk),
    .rst_n    (rst_b),
    .bus      (ifb)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // channel queue models: fill = loaded total - pops, record valid only RD_LAT cycles after the strobe
  int          a_tot  [4];
  int          a_pops [4];
  bit          a_dv   [4];
  logic [63:0] a_dr   [4];
  logic [31:0] a_stat;
  logic [255:0] a_data;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_a) begin
        a_pops[i] <= 0;
        a_dv[i]   <= 1'b0;
        a_dr[i]   <= '0;
      end else begin
        a_dv[i] <= ifa.ch_rd_en[i];
        a_dr[i] <= {32'hDEAD_BEEF, 16'(a_pops[i]), 16'(i)};
        if (ifa.ch_rd_en[i]) a_pops[i] <= a_pops[i] + 1;
      end
    end
  end

  always_comb begin
    a_stat = '0;
    a_data = '0;
    for (int i = 0; i < 4; i++) begin
      a_stat[i*8 +: 8]   = (a_tot[i] > a_pops[i]) ? 8'(a_tot[i] - a_pops[i]) : 8'd0;
      a_data[i*64 +: 64] = a_dv[i] ? a_dr[i] : 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end
  assign ifa.ch_rd_stat = a_stat;
  assign ifa.ch_rd_data = a_data;

  int          b_tot  [2];
  int          b_pops [2];
  bit          b_v    [2][3];
  logic [63:0] b_r    [2][3];
  logic [15:0] b_stat;
  logic [127:0] b_data;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_b) begin
        b_pops[i] <= 0;
        for (int s = 0; s < 3; s++) begin
          b_v[i][s] <= 1'b0;
          b_r[i][s] <= '0;
        end
      end else begin
        b_v[i][0] <= ifb.ch_rd_en[i];
        b_r[i][0] <= {32'hDEAD_BEEF, 16'(b_pops[i]), 16'(i)};
        for (int s = 1; s < 3; s++) begin
          b_v[i][s] <= b_v[i][s-1];
          b_r[i][s] <= b_r[i][s-1];
        end
        if (ifb.ch_rd_en[i]) b_pops[i] <= b_pops[i] + 1;
      end
    end
  end

  always_comb begin
    b_stat = '0;
    b_data = '0;
    for (int i = 0; i < 2; i++) begin
      b_stat[i*8 +: 8]   = (b_tot[i] > b_pops[i]) ? 8'(b_tot[i] - b_pops[i]) : 8'd0;
      b_data[i*64 +: 64] = b_v[i][2] ? b_r[i][2] : 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end
  assign ifb.ch_rd_stat = b_stat;
  assign ifb.ch_rd_data = b_data;

  // monitors sample on the falling edge: grants, out_valid cycles, accepted records
  int          a_gch[$], a_gcyc[$], a_vcyc[$], a_och[$];
  logic [63:0] a_odat[$];
  int          a_multi = 0;
  int          b_gch[$], b_gcyc[$], b_och[$];
  logic [63:0] b_odat[$];

  always @(negedge clk) begin
    if (rst_a) begin
      if (ifa.ch_rd_en != '0 && $countones(ifa.ch_rd_en) != 1) a_multi++;
      for (int i = 0; i < 4; i++) begin
        if (ifa.ch_rd_en[i]) begin
          a_gch.push_back(i);
          a_gcyc.push_back(cyc);
        end
      end
      if (ifa.out_valid) a_vcyc.push_back(cyc);
      if (ifa.out_valid && ifa.out_ready) begin
        a_och.push_back(int'(ifa.out_ch));
        a_odat.push_back(ifa.out_data);
      end
    end
    if (rst_b) begin
      for (int i = 0; i < 2; i++) begin
        if (ifb.ch_rd_en[i]) begin
          b_gch.push_back(i);
          b_gcyc.push_back(cyc);
        end
      end
      if (ifb.out_valid && ifb.out_ready) begin
        b_och.push_back(int'(ifb.out_ch));
        b_odat.push_back(ifb.out_data);
      end
    end
  end

  int rel;
  int cnt1;

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    ifa.ch_en = 4'hF;
    ifa.out_ready = 1'b0;
    a_tot = '{3, 3, 3, 3};
    ifb.ch_en = 2'b11;
    ifb.out_ready = 1'b1;
    b_tot = '{0, 0};
    cyc_wait(3);

    // reset state with every queue non-empty
    check("a_rst_rd_en", 64'(ifa.ch_rd_en), 64'd0);
    check("a_rst_valid", 64'(ifa.out_valid), 64'd0);
    check("a_rst_level", 64'(ifa.out_level), 64'd0);
    check("a_rst_busy", 64'(ifa.busy), 64'd0);
    check("a_rst_data", ifa.out_data, 64'd0);
    check("a_rst_ch", 64'(ifa.out_ch), 64'd0);

    // release: IDLE in the release cycle, RD for ch0 in the next; fill 4-deep FIFO with 0,1,2,3
    rel = cyc;
    rst_a = 1'b1;
    cyc_wait(40);
    check("a_first_grant_cyc", 64'(a_gcyc.size() > 0 ? a_gcyc[0] : -1), 64'(rel + 1));
    check("a_full_pops", 64'(a_gch.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("a_rr_ch%0d", k), 64'(k < a_gch.size() ? a_gch[k] : -1), 64'(k));
    end
    for (int k = 1; k < 4; k++) begin
      check($sformatf("a_rr_gap%0d", k),
            64'(k < a_gcyc.size() ? a_gcyc[k] - a_gcyc[k-1] : -1), 64'd5);
    end
    check("a_full_level", 64'(ifa.out_level), 64'd4);
    check("a_full_busy", 64'(ifa.busy), 64'd0);
    check("a_full_valid", 64'(ifa.out_valid), 64'd1);
    check("a_head_ch", 64'(ifa.out_ch), 64'd0);
    check("a_head_data", ifa.out_data, 64'hDEAD_BEEF_0000_0000);

    // a single accept frees one slot, which exactly one more pop refills
    ifa.out_ready = 1'b1;
    cyc_wait(1);
    ifa.out_ready = 1'b0;
    check("a_pulse_level", 64'(ifa.out_level), 64'd3);
    cyc_wait(12);
    check("a_refill_pops", 64'(a_gch.size()), 64'd5);
    check("a_refill_ch", 64'(a_gch.size() > 4 ? a_gch[4] : -1), 64'd0);
    check("a_refill_level", 64'(ifa.out_level), 64'd4);
    check("a_refill_busy", 64'(ifa.busy), 64'd0);

    // drain: remaining 7 records keep the rotation; free-running pops are 5 cycles apart
    ifa.out_ready = 1'b1;
    cyc_wait(60);
    check("a_total_pops", 64'(a_gch.size()), 64'd12);
    check("a_total_out", 64'(a_och.size()), 64'd12);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("a_seq_ch%0d", k), 64'(k < a_gch.size() ? a_gch[k] : -1), 64'(k % 4));
      check($sformatf("a_out_ch%0d", k), 64'(k < a_och.size() ? a_och[k] : -1), 64'(k % 4));
      check($sformatf("a_out_data%0d", k), k < a_odat.size() ? a_odat[k] : 64'hX,
            {32'hDEAD_BEEF, 16'(k / 4), 16'(k % 4)});
    end
    for (int k = 6; k < 12; k++) begin
      check($sformatf("a_free_gap%0d", k),
            64'(k < a_gcyc.size() ? a_gcyc[k] - a_gcyc[k-1] : -1), 64'd5);
    end
    check("a_drain_level", 64'(ifa.out_level), 64'd0);
    check("a_onehot", 64'(a_multi), 64'd0);

    // single channel: only ch1 holds one record
    rst_a = 1'b0;
    a_tot = '{0, 1, 0, 0};
    cyc_wait(2);
    a_gch.delete(); a_gcyc.delete(); a_vcyc.delete(); a_och.delete(); a_odat.delete();
    rst_a = 1'b1;
    cyc_wait(20);
    check("a_single_pops", 64'(a_gch.size()), 64'd1);
    check("a_single_grant", 64'(a_gch.size() > 0 ? a_gch[0] : -1), 64'd1);
    check("a_single_ch", 64'(a_och.size() > 0 ? a_och[0] : -1), 64'd1);
    check("a_single_data", a_odat.size() > 0 ? a_odat[0] : 64'hX, 64'hDEAD_BEEF_0000_0001);
    check("a_single_vcycles", 64'(a_vcyc.size()), 64'd1);
    check("a_single_vstart",
          64'(a_vcyc.size() > 0 && a_gcyc.size() > 0 ? a_vcyc[0] - a_gcyc[0] : -1), 64'd2);

    // masked ch1 never granted; CAP edge coincides with an accept at level 2
    rst_a = 1'b0;
    a_tot = '{3, 5, 0, 0};
    ifa.ch_en = 4'b0001;
    ifa.out_ready = 1'b0;
    cyc_wait(2);
    a_gch.delete(); a_gcyc.delete(); a_vcyc.delete(); a_och.delete(); a_odat.delete();
    rst_a = 1'b1;
    for (int t = 0; t < 60 && a_gch.size() < 3; t++) cyc_wait(1);
    check("a_mask_third_pop", 64'(a_gch.size()), 64'd3);
    check("a_cap_busy", 64'(ifa.busy), 64'd1);
    check("a_cap_level", 64'(ifa.out_level), 64'd2);
    ifa.out_ready = 1'b1;
    cyc_wait(1);
    ifa.out_ready = 1'b0;
    check("a_pushpop_level", 64'(ifa.out_level), 64'd2);
    check("a_pushpop_data", a_odat.size() > 0 ? a_odat[0] : 64'hX, 64'hDEAD_BEEF_0000_0000);
    cyc_wait(30);
    cnt1 = 0;
    foreach (a_gch[k]) if (a_gch[k] != 0) cnt1++;
    check("a_mask_other", 64'(cnt1), 64'd0);
    check("a_mask_pops", 64'(a_gch.size()), 64'd3);
    check("a_mask_level", 64'(ifa.out_level), 64'd2);

    // RD_LAT=3, STAT_LAT=0: data only valid at the capture cycle, period 5
    rst_b = 1'b0;
    b_tot = '{3, 0};
    cyc_wait(2);
    rst_b = 1'b1;
    cyc_wait(30);
    check("b_pops", 64'(b_gch.size()), 64'd3);
    check("b_out", 64'(b_och.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("b_grant%0d", k), 64'(k < b_gch.size() ? b_gch[k] : -1), 64'd0);
      check($sformatf("b_out_ch%0d", k), 64'(k < b_och.size() ? b_och[k] : -1), 64'd0);
      check($sformatf("b_out_data%0d", k), k < b_odat.size() ? b_odat[k] : 64'hX,
            {32'hDEAD_BEEF, 16'(k), 16'h0000});
    end
    for (int k = 1; k < 3; k++) begin
      check($sformatf("b_gap%0d", k),
            64'(k < b_gcyc.size() ? b_gcyc[k] - b_gcyc[k-1] : -1), 64'd5);
    end
    check("b_level", 64'(ifb.out_level), 64'd0);

    // reset during WAIT aborts the pop: no push after release
    rst_b = 1'b0;
    b_tot = '{2, 0};
    cyc_wait(2);
    b_gch.delete(); b_gcyc.delete(); b_och.delete(); b_odat.delete();
    rst_b = 1'b1;
    for (int t = 0; t < 20 && b_gch.size() < 1; t++) cyc_wait(1);
    check("b_wait_grant", 64'(b_gch.size()), 64'd1);
    check("b_wait_busy", 64'(ifb.busy), 64'd1);
    rst_b = 1'b0;
    b_tot = '{0, 0};
    cyc_wait(2);
    check("b_abort_level", 64'(ifb.out_level), 64'd0);
    check("b_abort_valid", 64'(ifb.out_valid), 64'd0);
    check("b_abort_busy", 64'(ifb.busy), 64'd0);
    check("b_abort_rd_en", 64'(ifb.ch_rd_en), 64'd0);
    rst_b = 1'b1;
    cyc_wait(20);
    check("b_abort_no_push", 64'(b_och.size()), 64'd0);
    check("b_abort_level2", 64'(ifb.out_level), 64'd0);
    check("b_abort_pops", 64'(b_gch.size()), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
